ahb3lite_imem_stub: RTL and testbench

Instruction-side AHB3-Lite slave that feeds the RV12 core's fetch unit in the formal and simulation harness. It serves 32-bit words from a preloadable array with a configurable number of wait states. It returns ERROR responses for illegal accesses and optionally replaces non-RV32I encodings with NOP, so every word the IF stage sees is legal.

---
 rtl/imem_pkg.sv | 68 ++++++
 rtl/rv32i_inst_filter.sv | 13 +
 rtl/ahb3lite_imem_stub.sv | 116 +++++++++++
 tb/tb_ahb3lite_imem_stub.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared encodings, FSM states and the RV32I legality check for the instruction memory stub.
package imem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_MISC   = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } rv32i_opc_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } imem_state_e;

  // Control-transfer immediates must keep imm[1] clear so every target stays word aligned.
  function automatic logic is_valid_rv32i(input logic [31:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = inst[14:12];
    f7 = inst[31:25];
    ok = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: ok = 1'b1;
      OPC_JAL:            ok = ~inst[21];
      OPC_JALR:           ok = (f3 == 3'd0) && !inst[21];
      OPC_BRANCH:         ok = (f3 != 3'd2) && (f3 != 3'd3) && !inst[8];
      OPC_LOAD:           ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                               (f3 == 3'd4) || (f3 == 3'd5);
      OPC_STORE:          ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      OPC_OPIMM: begin
        case (f3)
          3'd1:    ok = (f7 == 7'b0000000);
          3'd5:    ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: ok = 1'b1;
        endcase
      end
      OPC_OP:             ok = (f7 == 7'b0000000) ||
                               ((f7 == 7'b0100000) && ((f3 == 3'd0) || (f3 == 3'd5)));
      OPC_MISC:           ok = (f3 == 3'd0);
      OPC_SYSTEM:         ok = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv32i_inst_filter.sv
// Combinational RV32I legality filter: illegal encodings are replaced by NOP and flagged.
module rv32i_inst_filter
  import imem_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] inst_out,
  output logic        illegal
);

  assign illegal  = ~is_valid_rv32i(inst);
  assign inst_out = illegal ? RV_NOP : inst;

endmodule

// File: rtl/ahb3lite_imem_stub.sv
// AHB3-Lite instruction memory stub with preload port, wait states and ERROR responses.
// Define IMEM_ILLEGAL_FILTER_EN to replace non-RV32I words with NOP and pulse illegal_sub.
module ahb3lite_imem_stub
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     HSEL,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic [31:0]              fetch_cnt,
  output logic                     illegal_sub
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  imem_state_e   state, state_n;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] idx_q, rd_idx;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   off, rd_word, cap_word;
  logic          accept, bad, enter_data, cap_ill;

  // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range check.
  assign off    = HADDR - BASE_ADDR;
  assign accept = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                  ((state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2));
  assign bad    = HWRITE || (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) || (off >= SPAN);

  always_comb begin
    state_n   = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_n = ST_IDLE;
        if (accept) state_n = bad ? ST_ERR1 : ((WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA);
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == WAIT_LAST) state_n = ST_DATA;
      end
      // Master may drop HTRANS here; the second error cycle is unconditional.
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        state_n   = ST_ERR2;
      end
      default: state_n = ST_IDLE;
    endcase
    if ((state == ST_ERR1) || (state == ST_ERR2)) HRESP = HRESP_ERROR;
  end

  assign enter_data = (state_n == ST_DATA);
  assign rd_idx     = (state == ST_WAIT) ? idx_q : off[AW+1:2];
  assign rd_word    = mem[rd_idx];

  // No reset on the array so preloaded contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

`ifdef IMEM_ILLEGAL_FILTER_EN
  logic ill_q;

  rv32i_inst_filter u_filter (
    .inst    (rd_word),
    .inst_out(cap_word),
    .illegal (cap_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) ill_q <= 1'b0;
    else     ill_q <= enter_data && cap_ill;
  end

  assign illegal_sub = ill_q;
`else
  assign cap_word    = rd_word;
  assign cap_ill     = 1'b0;
  assign illegal_sub = cap_ill;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      idx_q     <= '0;
      HRDATA    <= 32'd0;
      fetch_cnt <= 32'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= ((state == ST_WAIT) && (state_n == ST_WAIT)) ? wait_cnt + 4'd1 : 4'd0;
      if (accept) idx_q <= off[AW+1:2];
      if (enter_data) begin
        HRDATA    <= cap_word;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_imem_stub.sv
// Directed bench: one zero-wait and one three-wait instance share bus and preload stimulus.
module tb_ahb3lite_imem_stub;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0] hrdata0, hrdata3, fcnt0, fcnt3;
  logic        rdy0, rdy3, resp0, resp3, ill0, ill3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahb3lite_imem_stub #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HREADY(rdy0), .HRDATA(hrdata0), .HREADYOUT(rdy0), .HRESP(resp0),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fcnt0), .illegal_sub(ill0)
  );

  ahb3lite_imem_stub #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HREADY(rdy3), .HRDATA(hrdata3), .HREADYOUT(rdy3), .HRESP(resp3),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fcnt3), .illegal_sub(ill3)
  );

  logic [31:0] m [8] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213,
                         32'h0040_0293, 32'hFFFF_FFFF, 32'h0020_006F, 32'h0070_0393};

`ifdef IMEM_ILLEGAL_FILTER_EN
  localparam logic [31:0] EXP_W5 = 32'h0000_0013;
  localparam logic [31:0] EXP_W6 = 32'h0000_0013;
  localparam logic        EXP_IL = 1'b1;
`else
  localparam logic [31:0] EXP_W5 = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_W6 = 32'h0020_006F;
  localparam logic        EXP_IL = 1'b0;
`endif

  int exp_fc0 = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'b010; haddr = '0;
  endtask

  task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                     input logic exp_il);
    haddr = a; htrans = HTRANS_NONSEQ; hsel0 = 1'b1;
    tick(); bus_idle(); exp_fc0++;
    chk({tag, "_data"}, hrdata0, exp_d);
    chk({tag, "_rdy"}, rdy0, 1'b1);
    chk({tag, "_resp"}, resp0, 1'b0);
    chk({tag, "_ill"}, ill0, exp_il);
    chk({tag, "_fcnt"}, fcnt0, exp_fc0);
    tick();
  endtask

  task automatic err0(input string tag, input logic [31:0] a, input logic w, input logic [2:0] sz);
    haddr = a; hwrite = w; hsize = sz; htrans = HTRANS_NONSEQ; hsel0 = 1'b1;
    tick(); bus_idle();
    chk({tag, "_e1_rdy"}, rdy0, 1'b0);
    chk({tag, "_e1_resp"}, resp0, 1'b1);
    tick();
    chk({tag, "_e2_rdy"}, rdy0, 1'b1);
    chk({tag, "_e2_resp"}, resp0, 1'b1);
    tick();
    chk({tag, "_idle_resp"}, resp0, 1'b0);
    chk({tag, "_fcnt"}, fcnt0, exp_fc0);
  endtask

  initial begin
    int cyc, k;
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    bus_idle();
    tick(); tick();
    chk("rst_rdy", rdy0, 1'b1);
    chk("rst_resp", resp0, 1'b0);
    chk("rst_data", hrdata0, 32'd0);
    chk("rst_fcnt", fcnt0, 32'd0);
    chk("rst_ill", ill0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ld_we = 1'b1; ld_addr = 8'(i); ld_data = m[i];
      tick();
    end
    ld_we = 1'b0;

    // Zero-wait single and back-to-back reads
    rd0("rd200", 32'h200, m[0], 1'b0);
    chk("idle_rdy", rdy0, 1'b1);
    haddr = 32'h204; htrans = HTRANS_NONSEQ; hsel0 = 1'b1;
    tick();
    chk("b2b0_d1", hrdata0, m[1]);
    haddr = 32'h208; htrans = HTRANS_SEQ;
    tick(); bus_idle(); exp_fc0 += 2;
    chk("b2b0_d2", hrdata0, m[2]);
    chk("b2b0_fcnt", fcnt0, exp_fc0);
    tick();

    // Error responses
    err0("wr200", 32'h200, 1'b1, 3'b010);
    err0("rd202", 32'h202, 1'b0, 3'b010);
    err0("rd600", 32'h600, 1'b0, 3'b010);
    err0("rd1fc", 32'h1FC, 1'b0, 3'b010);
    err0("sz0", 32'h200, 1'b0, 3'b000);

    // New address phase accepted during ERR2
    haddr = 32'h200; hwrite = 1'b1; htrans = HTRANS_NONSEQ; hsel0 = 1'b1;
    tick(); bus_idle();
    tick();
    haddr = 32'h20C; htrans = HTRANS_NONSEQ; hsel0 = 1'b1;
    tick(); bus_idle(); exp_fc0++;
    chk("err2_acc_data", hrdata0, m[3]);
    chk("err2_acc_resp", resp0, 1'b0);
    tick();

    // Filter
    rd0("rd_ffff", 32'h214, EXP_W5, EXP_IL);
    chk("ill_pulse_end", ill0, 1'b0);
    chk("data_hold", hrdata0, EXP_W5);
    rd0("rd_jal_mis", 32'h218, EXP_W6, EXP_IL);

    // Read-before-write on the capture edge
    haddr = 32'h21C; htrans = HTRANS_NONSEQ; hsel0 = 1'b1;
    ld_we = 1'b1; ld_addr = 8'd7; ld_data = 32'h0080_0413;
    tick(); bus_idle(); ld_we = 1'b0; exp_fc0++;
    chk("rbw_old", hrdata0, m[7]);
    tick();
    rd0("rbw_new", 32'h21C, 32'h0080_0413, 1'b0);

    // Three wait states
    haddr = 32'h204; htrans = HTRANS_NONSEQ; hsel3 = 1'b1;
    tick(); bus_idle();
    chk("w3_c1_rdy", rdy3, 1'b0);
    tick(); chk("w3_c2_rdy", rdy3, 1'b0);
    tick(); chk("w3_c3_rdy", rdy3, 1'b0);
    chk("w3_c3_resp", resp3, 1'b0);
    tick();
    chk("w3_data_rdy", rdy3, 1'b1);
    chk("w3_data", hrdata3, m[1]);
    chk("w3_fcnt", fcnt3, 32'd1);
    tick();

    // Four back-to-back reads at three wait states
    cyc = 0; k = 0;
    haddr = 32'h200; htrans = HTRANS_NONSEQ; hsel3 = 1'b1;
    while (k < 4 && cyc < 40) begin
      tick(); cyc++;
      if (rdy3) begin
        chk("w3_b2b_data", hrdata3, m[k]);
        k++;
        if (k < 4) begin
          haddr = 32'h200 + 32'(4 * k); htrans = HTRANS_SEQ;
        end else bus_idle();
      end
    end
    bus_idle();
    chk("w3_b2b_cycles", 32'(cyc), 32'd16);
    chk("w3_b2b_fcnt", fcnt3, 32'd5);
    tick();

    // Reset during the second wait cycle
    haddr = 32'h204; htrans = HTRANS_NONSEQ; hsel3 = 1'b1;
    tick(); bus_idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rdy", rdy3, 1'b1);
    chk("mid_rst_resp", resp3, 1'b0);
    chk("mid_rst_data", hrdata3, 32'd0);
    chk("mid_rst_fcnt", fcnt3, 32'd0);
    tick();
    chk("post_rst_idle_rdy", rdy3, 1'b1);

    haddr = 32'h208; htrans = HTRANS_NONSEQ; hsel3 = 1'b1;
    tick(); bus_idle();
    cyc = 0;
    while (!rdy3 && cyc < 10) begin
      tick(); cyc++;
    end
    chk("keep_lat", 32'(cyc), 32'd3);
    chk("keep_data", hrdata3, m[2]);
    chk("keep_fcnt", fcnt3, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
